// File: rtl/reg_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the elastic register chain.
package reg_pipe_pkg;

    localparam int MAX_DEPTH       = 16;
    localparam int DEFAULT_RST_VAL = 0;

    // Simultaneous input/output handshake pattern: {input accept, output accept}
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_OUT  = 2'b01,
        XFER_IN   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    function automatic int popcount(input logic [MAX_DEPTH-1:0] mask);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (mask[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One slot of the chain: either a valid/ready register or a combinational pass-through.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter bit               REGON   = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (REGON) begin : g_reg
            logic             v_q, v_d;
            logic [WIDTH-1:0] d_q, d_d;
            logic             load_s;

            // An empty slot always accepts, which is what collapses bubbles.
            assign in_ready  = ~v_q | out_ready;
            assign load_s    = ce & ~flush & in_ready;
            assign out_valid = v_q;
            assign out_data  = d_q;

            // Next-state: flush clears valid, a load takes the upstream word.
            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (flush) begin
                    v_d = 1'b0;
                end else if (load_s) begin
                    v_d = in_valid;
                    if (in_valid) begin
                        d_d = in_data;
                    end else begin
                        d_d = d_q;
                    end
                end else begin
                    v_d = v_q;
                end
            end

            // Slot state with asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    d_q <= RST_VAL;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end
        end else begin : g_bypass
            logic unused_s;

            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign unused_s  = ^{clk, rst, ce, flush};
        end
    endgenerate

endmodule

// File: rtl/reg_pipe.sv
// Elastic pipeline of DEPTH slots with per-slot register/bypass selection and an occupancy counter.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = 18,
    parameter int               DEPTH      = 4,
    parameter logic [DEPTH-1:0] STAGE_MASK = {DEPTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL    = WIDTH'(DEFAULT_RST_VAL)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam logic [MAX_DEPTH-1:0] MASK_EXT = MAX_DEPTH'(STAGE_MASK);
    localparam int                   NREG     = popcount(MASK_EXT);
    localparam int                   OCC_W    = occ_width(DEPTH);

    // Each slot keeps its own nets so the ready chain is not one self-dependent vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;
        logic             dn_ready_s;
        logic             valid_s;
        logic             ready_s;
        logic [WIDTH-1:0] data_s;

        if (i == 0) begin : g_head
            assign up_valid_s = in_valid;
            assign up_data_s  = in_data;
        end else begin : g_link
            assign up_valid_s = g_slot[i-1].valid_s;
            assign up_data_s  = g_slot[i-1].data_s;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready_s = out_ready;
        end else begin : g_next
            assign dn_ready_s = g_slot[i+1].ready_s;
        end

        reg_pipe_stage #(
            .WIDTH   (WIDTH),
            .REGON   (STAGE_MASK[i]),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .flush     (flush),
            .in_valid  (up_valid_s),
            .in_ready  (ready_s),
            .in_data   (up_data_s),
            .out_valid (valid_s),
            .out_ready (dn_ready_s),
            .out_data  (data_s)
        );
    end

    assign in_ready  = g_slot[0].ready_s & ce & ~flush & ~rst;
    assign out_valid = g_slot[DEPTH-1].valid_s & ce & ~flush & ~rst;
    assign out_data  = g_slot[DEPTH-1].data_s;

    generate
        if (NREG == 0) begin : g_no_occ
            assign occupancy = {OCC_W{1'b0}};
        end else begin : g_occ
            logic [OCC_W-1:0] occ_q, occ_d;
            xfer_e            xfer_s;

            assign xfer_s    = xfer_e'({in_valid & in_ready, out_valid & out_ready});
            assign occupancy = occ_q;

            // Occupancy tracks net words entering minus words leaving.
            always_comb begin
                occ_d = occ_q;
                if (flush) begin
                    occ_d = {OCC_W{1'b0}};
                end else if (ce) begin
                    case (xfer_s)
                        XFER_IN:  occ_d = occ_q + OCC_W'(1);
                        XFER_OUT: occ_d = occ_q - OCC_W'(1);
                        default:  occ_d = occ_q;
                    endcase
                end else begin
                    occ_d = occ_q;
                end
            end

            // Occupancy register with asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    occ_q <= {OCC_W{1'b0}};
                end else begin
                    occ_q <= occ_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: three mask configurations driven in parallel, word-position model plus directed checks.
module tb_reg_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [17:0] in_data = 18'd0;

    logic        f_ir, f_ov, h_ir, h_ov, w_ir, w_ov;
    logic [17:0] f_od, h_od, w_od;
    logic [2:0]  f_oc, h_oc, w_oc;

    reg_pipe #(.WIDTH(18), .DEPTH(4), .STAGE_MASK(4'b1111), .RST_VAL(18'h00155)) u_full (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(f_ir), .in_data(in_data),
        .out_valid(f_ov), .out_ready(out_ready), .out_data(f_od), .occupancy(f_oc));

    reg_pipe #(.WIDTH(18), .DEPTH(4), .STAGE_MASK(4'b0101)) u_half (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(h_ir), .in_data(in_data),
        .out_valid(h_ov), .out_ready(out_ready), .out_data(h_od), .occupancy(h_oc));

    reg_pipe #(.WIDTH(18), .DEPTH(4), .STAGE_MASK(4'b0000)) u_wire (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(w_ir), .in_data(in_data),
        .out_valid(w_ov), .out_ready(out_ready), .out_data(w_od), .occupancy(w_oc));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: per registered pipe, a list of words (oldest first) with their slot position
    // among the NREG registered slots; each cycle every word moves one slot forward unless
    // the word ahead blocks it; the oldest word is visible once it sits in the last slot.
    int          NR[2] = '{4, 2};
    int          mn[2];
    int          mp[2][16];
    logic [17:0] md[2][16];
    int          acc_c[2][64];
    int          out_c[2][64];

    initial begin
        logic        eir, eov, in_acc, out_acc;
        logic        dir[2], dov[2];
        logic [17:0] dod[2];
        logic [2:0]  doc[2];
        int          nr, cap, nxt;
        for (int j = 0; j < 2; j++) begin
            mn[j] = 0;
            for (int k = 0; k < 64; k++) begin
                acc_c[j][k] = -1;
                out_c[j][k] = -1;
            end
        end
        forever begin
            @(negedge clk);
            dir[0] = f_ir; dov[0] = f_ov; dod[0] = f_od; doc[0] = f_oc;
            dir[1] = h_ir; dov[1] = h_ov; dod[1] = h_od; doc[1] = h_oc;
            if (rst) begin
                mn[0] = 0;
                mn[1] = 0;
                chk("rst_out_valid_full", dov[0], 1'b0);
                chk("rst_out_valid_half", dov[1], 1'b0);
                chk("rst_occ_full", doc[0], 0);
            end else begin
                chk("wire_out_data", w_od, in_data);
                chk("wire_out_valid", w_ov, in_valid & ce & ~flush);
                chk("wire_in_ready", w_ir, out_ready & ce & ~flush);
                chk("wire_occ", w_oc, 0);
                for (int j = 0; j < 2; j++) begin
                    nr  = NR[j];
                    eir = ce && !flush && ((mn[j] < nr) || out_ready);
                    eov = ce && !flush && (mn[j] > 0) && (mp[j][0] == nr - 1);
                    chk(j == 0 ? "in_ready_full" : "in_ready_half", dir[j], eir);
                    chk(j == 0 ? "out_valid_full" : "out_valid_half", dov[j], eov);
                    chk(j == 0 ? "occ_full" : "occ_half", doc[j], mn[j]);
                    if (eov) begin
                        chk(j == 0 ? "out_data_full" : "out_data_half", dod[j], md[j][0]);
                    end
                    in_acc  = in_valid && eir;
                    out_acc = eov && out_ready;
                    if (in_acc) acc_c[j][in_data[5:0]] = cyc;
                    if (out_acc) out_c[j][md[j][0][5:0]] = cyc;
                    if (flush) begin
                        mn[j] = 0;
                    end else if (ce) begin
                        if (out_acc) begin
                            for (int k = 0; k < mn[j] - 1; k++) begin
                                mp[j][k] = mp[j][k+1];
                                md[j][k] = md[j][k+1];
                            end
                            mn[j]--;
                        end
                        for (int k = 0; k < mn[j]; k++) begin
                            cap = (k == 0) ? nr - 1 : mp[j][k-1] - 1;
                            nxt = mp[j][k] + 1;
                            mp[j][k] = (nxt < cap) ? nxt : cap;
                        end
                        if (in_acc) begin
                            md[j][mn[j]] = in_data;
                            mp[j][mn[j]] = 0;
                            mn[j]++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        ce        = 1'b1;
        repeat (8) tick();
    endtask

    task automatic push(input logic [17:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("push_in_ready", f_ir, 1'b1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        repeat (2) tick();
        chk("reset_out_valid", f_ov, 1'b0);
        chk("reset_occ", f_oc, 0);
        chk("reset_data", f_od, 18'h00155);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", f_ir, 1'b1);

        // Streaming 1..8 with no stall
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(k);
            #1;
            chk("stream_in_ready", f_ir, 1'b1);
            tick();
            if (k == 4) chk("stream_occ_4", f_oc, 4);
        end
        drain();
        chk("stream_latency_full", out_c[0][1] - acc_c[0][1], 4);
        chk("stream_latency_half", out_c[1][1] - acc_c[1][1], 2);
        for (int k = 1; k < 8; k++) chk("stream_back_to_back", out_c[0][k+1] - out_c[0][k], 1);

        // Backpressure: four accepted, fifth waits
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(18'(11 + k));
        in_valid = 1'b1;
        in_data  = 18'd15;
        #1;
        chk("bp_in_ready_low", f_ir, 1'b0);
        chk("bp_occ_full", f_oc, 4);
        tick();
        chk("bp_in_ready_still_low", f_ir, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", f_ir, 1'b1);
        tick();
        push(18'd16);
        drain();
        for (int k = 11; k < 16; k++) chk("bp_order_no_gap", out_c[0][k+1] - out_c[0][k], 1);

        // Bubble collapse: A then B six cycles later
        out_ready = 1'b0;
        push(18'd21);
        in_valid = 1'b0;
        repeat (5) tick();
        push(18'd22);
        in_valid = 1'b0;
        repeat (2) tick();
        chk("bubble_occ", f_oc, 2);
        chk("bubble_out_valid", f_ov, 1'b1);
        chk("bubble_head", f_od, 18'd21);
        drain();
        chk("bubble_back_to_back", out_c[0][22] - out_c[0][21], 1);

        // Flush with three in flight and a word offered during the flush cycle
        out_ready = 1'b0;
        push(18'd31);
        push(18'd32);
        push(18'd33);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 18'd34;
        #1;
        chk("flush_in_ready", f_ir, 1'b0);
        chk("flush_out_valid", f_ov, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_occ", f_oc, 0);
        out_ready = 1'b1;
        push(18'd35);
        drain();
        chk("flush_next_latency", out_c[0][35] - acc_c[0][35], 4);
        for (int k = 31; k <= 34; k++) chk("flush_no_stale", out_c[0][k], -1);

        // Clock enable low for three cycles mid-stream
        out_ready = 1'b1;
        push(18'd41);
        push(18'd42);
        push(18'd43);
        ce       = 1'b0;
        in_valid = 1'b1;
        in_data  = 18'd44;
        repeat (3) begin
            #1;
            chk("ce_in_ready", f_ir, 1'b0);
            chk("ce_out_valid", f_ov, 1'b0);
            tick();
        end
        ce = 1'b1;
        for (int k = 44; k <= 48; k++) push(18'(k));
        drain();
        chk("ce_latency", out_c[0][41] - acc_c[0][41], 7);
        for (int k = 41; k < 48; k++) chk("ce_order", out_c[0][k+1] - out_c[0][k], 1);

        // Asynchronous reset between clock edges with words held
        out_ready = 1'b0;
        push(18'd51);
        push(18'd52);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("pre_rst_out_valid", f_ov, 1'b1);
        chk("pre_rst_occ", f_oc, 2);
        chk("pre_rst_data", f_od, 18'd51);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pulse_out_valid", f_ov, 1'b0);
        chk("rst_pulse_occ", f_oc, 0);
        chk("rst_pulse_data", f_od, 18'h00155);
        tick();
        rst = 1'b0;
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 18'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            ce        = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
